// File: rtl/sram_lsu_pkg.sv
// Shared types and helpers for the LSU-to-SRAM-controller bridge.
package sram_lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } sram_lsu_state_e;

  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [18:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // size[1:0] encodes the access width for both signed and unsigned loads
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] size,
                                                     input logic [1:0] off);
    case (size[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] size,
                                             input logic [31:0] wd);
    case (size[1:0])
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic access_legal(input logic wr, input logic [2:0] size,
                                        input logic [1:0] off);
    logic size_ok;
    if (wr) size_ok = (size == SB) || (size == SH) || (size == SW);
    else    size_ok = (size == LB) || (size == LH) || (size == LW) ||
                      (size == LBU) || (size == LHU);
    case (size[1:0])
      2'b01:   access_legal = size_ok && !off[0];
      2'b10:   access_legal = size_ok && (off == 2'b00);
      default: access_legal = size_ok;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a 32-bit SRAM word and extends it.
module lsu_load_align
  import sram_lsu_pkg::*;
(
  input  logic [31:0] rdata_q,
  input  logic [1:0]  addr_q,
  input  logic [2:0]  size_q,
  output logic [31:0] rdata_o
);

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;

  always_comb begin
    lanes    = rdata_q;
    byte_sel = lanes[addr_q];
    half_sel = addr_q[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
    case (size_q)
      LB:      rdata_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      rdata_o = {{16{half_sel[15]}}, half_sel};
      LBU:     rdata_o = {24'h0, byte_sel};
      LHU:     rdata_o = {16'h0, half_sel};
      default: rdata_o = rdata_q;
    endcase
  end

endmodule

// File: rtl/sram_lsu_bridge.sv
// Stalls the core for one SRAM controller transaction per load/store and
// returns formatted load data plus misalign/timeout flags.
module sram_lsu_bridge
  import sram_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15,
  parameter int SRAM_AW     = 18
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [31:0]        i_lsu_addr,
  input  logic [31:0]        i_lsu_wdata,
  input  logic [2:0]         i_lsu_size,
  input  logic               i_lsu_wren,
  input  logic               i_lsu_rden,
  output logic [31:0]        o_lsu_rdata,
  output logic               o_lsu_stall,
  output logic               o_lsu_misaligned,
  output logic               o_lsu_timeout,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [31:0]        o_sram_wdata,
  output logic [3:0]         o_sram_bmask,
  output logic               o_sram_wren,
  output logic               o_sram_rden,
  input  logic [31:0]        i_sram_rdata,
  input  logic               i_sram_ack
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  sram_lsu_state_e state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            to_q, to_d;

  logic            one_req;
  logic            legal;
  logic            bus_active;
  logic [31:0]     aligned;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^i_lsu_addr[31:19];
  assign one_req        = i_lsu_wren ^ i_lsu_rden;
  assign legal          = access_legal(i_lsu_wren, i_lsu_size, i_lsu_addr[1:0]);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (one_req) begin
          req_d   = '{wr: i_lsu_wren, size: i_lsu_size,
                      addr: i_lsu_addr[18:0], wdata: i_lsu_wdata};
          rdata_d = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
          mis_d   = !legal;
          state_d = legal ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // ack wins over a timeout landing in the same cycle
        if (i_sram_ack) begin
          rdata_d = i_sram_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_load_align u_align (
    .rdata_q (rdata_q),
    .addr_q  (req_q.addr[1:0]),
    .size_q  (req_q.size),
    .rdata_o (aligned)
  );

  always_comb begin
    bus_active       = (state_q == ST_REQ) || (state_q == ST_WAIT);
    o_lsu_stall      = (state_q == ST_IDLE) ? one_req : (state_q != ST_DONE);
    o_lsu_misaligned = (state_q == ST_DONE) && mis_q;
    o_lsu_timeout    = (state_q == ST_DONE) && to_q;
    o_lsu_rdata      = ((state_q == ST_DONE) && !mis_q) ? aligned : 32'h0;
    // single-cycle pulse: the controller re-samples requests while acking
    o_sram_wren      = (state_q == ST_REQ) && req_q.wr;
    o_sram_rden      = (state_q == ST_REQ) && !req_q.wr;
    o_sram_addr      = '0;
    o_sram_bmask     = '0;
    o_sram_wdata     = '0;
    if (bus_active) begin
      o_sram_addr  = SRAM_AW'({req_q.addr[18:2], 1'b0});
      o_sram_bmask = lane_mask(req_q.size, req_q.addr[1:0]);
      o_sram_wdata = lane_wdata(req_q.size, req_q.wdata);
    end
  end

endmodule
